// File: rtl/fifo_pkt_ctrl.sv
// fifo_pkt_ctrl: packet-aware write/read pointer controller for an external
// byte RAM of 2^DEPTH_BITS entries. Bytes of a packet are written
// speculatively and only become readable once the packet's last byte lands.
// Aborted, restarted or overflowing packets are rolled back to the last
// committed position.
// Optional feature macro: FIFO_PKT_CNT_EN enables the committed-packet
// counter (pkt_count) and its end-of-packet marker bitmap; without it
// pkt_count reads as zero.

module fifo_pkt_ctrl #(
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_valid,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic                  wr_err,
  input  logic                  rd_en,
  output logic                  wr_en,
  output logic [DEPTH_BITS-1:0] wr_addr,
  output logic [DEPTH_BITS-1:0] rd_addr,
  output logic                  rd_avail,
  output logic [DEPTH_BITS:0]   count_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  overflow,
  output logic [DEPTH_BITS:0]   pkt_count
);

  localparam int PW = DEPTH_BITS + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** DEPTH_BITS);
  localparam logic [PW-1:0] ONE   = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] wptr;
  logic [PW-1:0] cptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_nxt;
  logic [PW-1:0] cptr_nxt;
  logic [PW-1:0] wr_idx;
  logic          overflow_nxt;
  logic          do_commit;
  logic          rd_fire;

  assign count_out  = wptr - rptr;
  assign fifo_full  = (count_out == DEPTH);
  assign fifo_empty = (count_out == '0);
  assign rd_avail   = (cptr != rptr);
  assign rd_addr    = rptr[DEPTH_BITS-1:0];
  assign rd_fire    = rd_en & rd_avail;
  assign wr_addr    = wr_idx[DEPTH_BITS-1:0];

  // Packet FSM: decides whether the offered byte is written, where, and how the
  // speculative/committed write pointers move. In IDLE and DROP wptr equals cptr.
  always_comb begin
    state_nxt    = state;
    wptr_nxt     = wptr;
    cptr_nxt     = cptr;
    overflow_nxt = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = wptr;
    do_commit    = 1'b0;
    case (state)
      IDLE, DROP: begin
        if ((state == DROP) && wr_err) begin
          state_nxt = IDLE;
        end else if (wr_valid && wr_sop) begin
          if (fifo_full) begin
            overflow_nxt = 1'b1;
            wptr_nxt     = cptr;
            state_nxt    = wr_eop ? IDLE : DROP;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = wptr;
            wptr_nxt = wptr + ONE;
            if (wr_eop) begin
              cptr_nxt  = wptr + ONE;
              do_commit = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = RECV;
            end
          end
        end else if ((state == DROP) && wr_valid && wr_eop) begin
          state_nxt = IDLE;
        end
      end
      RECV: begin
        if (wr_err) begin
          wptr_nxt  = cptr;
          state_nxt = IDLE;
        end else if (wr_valid) begin
          if (fifo_full) begin
            overflow_nxt = 1'b1;
            wptr_nxt     = cptr;
            state_nxt    = wr_eop ? IDLE : DROP;
          end else if (wr_sop) begin
            wr_en    = 1'b1;
            wr_idx   = cptr;
            wptr_nxt = cptr + ONE;
            if (wr_eop) begin
              cptr_nxt  = cptr + ONE;
              do_commit = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            wr_en    = 1'b1;
            wr_idx   = wptr;
            wptr_nxt = wptr + ONE;
            if (wr_eop) begin
              cptr_nxt  = wptr + ONE;
              do_commit = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and pointer registers; reads advance rptr only over committed bytes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      wptr     <= '0;
      cptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      wptr     <= wptr_nxt;
      cptr     <= cptr_nxt;
      overflow <= overflow_nxt;
      if (rd_fire) begin
        rptr <= rptr + ONE;
      end
    end
  end

`ifdef FIFO_PKT_CNT_EN
  logic [(2**DEPTH_BITS)-1:0] eop_mark;
  logic                       pkt_inc;
  logic                       pkt_dec;

  assign pkt_inc = do_commit;
  assign pkt_dec = rd_fire & eop_mark[rptr[DEPTH_BITS-1:0]];

  // Tracks which RAM slots hold a packet's last byte and counts whole packets.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      eop_mark  <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_en) begin
        eop_mark[wr_addr] <= do_commit;
      end
      if (pkt_inc && !pkt_dec) begin
        pkt_count <= pkt_count + ONE;
      end else if (pkt_dec && !pkt_inc) begin
        pkt_count <= pkt_count - ONE;
      end
    end
  end
`else
  logic pkt_unused;

  assign pkt_unused = do_commit;
  assign pkt_count  = '0;
`endif

endmodule

// File: tb/tb_fifo_pkt_ctrl.sv
// tb_fifo_pkt_ctrl: directed-vector bench for fifo_pkt_ctrl at DEPTH_BITS=4.
// Each task drives one scenario and compares outputs against hand-computed
// values. Expected pkt_count values follow FIFO_PKT_CNT_EN.

module tb_fifo_pkt_ctrl;

  logic       clk;
  logic       n_rst;
  logic       wr_valid;
  logic       wr_sop;
  logic       wr_eop;
  logic       wr_err;
  logic       rd_en;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
  logic       rd_avail;
  logic [4:0] count_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic [4:0] pkt_count;

  int vectors;
  int miscompares;

  fifo_pkt_ctrl #(.DEPTH_BITS(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .wr_valid   (wr_valid),
    .wr_sop     (wr_sop),
    .wr_eop     (wr_eop),
    .wr_err     (wr_err),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .rd_avail   (rd_avail),
    .count_out  (count_out),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .pkt_count  (pkt_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected packet count given the number of packets the bench believes are committed.
  function automatic logic [4:0] exp_pkt(input int n);
`ifdef FIFO_PKT_CNT_EN
    return 5'(n);
`else
    return (n >= 0) ? 5'd0 : 5'd0;
`endif
  endfunction

  // Apply one cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic v, input logic s, input logic e,
                       input logic er, input logic rd);
    wr_valid = v;
    wr_sop   = s;
    wr_eop   = e;
    wr_err   = er;
    rd_en    = rd;
    #1;
  endtask

  // Advance past the next rising edge so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    vectors++;
    if (count_out !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d, expected 0", count_out); end
    vectors++;
    if (fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %0b, expected 1", fifo_empty); end
    vectors++;
    if (fifo_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %0b, expected 0", fifo_full); end
    vectors++;
    if (rd_avail !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_avail: got %0b, expected 0", rd_avail); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %0b, expected 0", overflow); end
    vectors++;
    if (pkt_count !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_pkt_count: got %0d, expected 0", pkt_count); end
    vectors++;
    if (rd_addr !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_rd_addr: got %0d, expected 0", rd_addr); end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_three_byte();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd0) begin miscompares++; $display("[TB] FAIL tb_byte0: got en=%0b addr=%0d, expected en=1 addr=0", wr_en, wr_addr); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd1) begin miscompares++; $display("[TB] FAIL tb_byte1: got en=%0b addr=%0d, expected en=1 addr=1", wr_en, wr_addr); end
    vectors++;
    if (rd_avail !== 1'b0) begin miscompares++; $display("[TB] FAIL tb_uncommitted: got %0b, expected 0", rd_avail); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd2) begin miscompares++; $display("[TB] FAIL tb_byte2: got en=%0b addr=%0d, expected en=1 addr=2", wr_en, wr_addr); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rd_avail !== 1'b1) begin miscompares++; $display("[TB] FAIL tb_committed: got %0b, expected 1", rd_avail); end
    vectors++;
    if (count_out !== 5'd3) begin miscompares++; $display("[TB] FAIL tb_count: got %0d, expected 3", count_out); end
    vectors++;
    if (pkt_count !== exp_pkt(1)) begin miscompares++; $display("[TB] FAIL tb_pkt_count: got %0d, expected %0d", pkt_count, exp_pkt(1)); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (rd_addr !== 4'(i)) begin miscompares++; $display("[TB] FAIL tb_rd_addr: got %0d, expected %0d", rd_addr, i); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rd_avail !== 1'b0 || fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL tb_drained: got avail=%0b empty=%0b, expected avail=0 empty=1", rd_avail, fifo_empty); end
  endtask

  task automatic test_abort();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    // wr_err together with a valid eop byte: the abort must win
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_wr_en: got %0b, expected 0", wr_en); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (count_out !== 5'd0) begin miscompares++; $display("[TB] FAIL abort_count: got %0d, expected 0", count_out); end
    vectors++;
    if (rd_avail !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_rd_avail: got %0b, expected 0", rd_avail); end
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd0) begin miscompares++; $display("[TB] FAIL abort_rewrite: got en=%0b addr=%0d, expected en=1 addr=0", wr_en, wr_addr); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count_out !== 5'd1 || rd_avail !== 1'b1 || rd_addr !== 4'd0) begin miscompares++; $display("[TB] FAIL abort_after: got count=%0d avail=%0b rd_addr=%0d, expected 1 1 0", count_out, rd_avail, rd_addr); end
  endtask

  task automatic test_restart_and_guard();
    do_reset();
    // a read with nothing committed is ignored, and IDLE drops a byte without sop
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL guard_no_sop: got %0b, expected 0", wr_en); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    vectors++;
    if (rd_addr !== 4'd0 || count_out !== 5'd2) begin miscompares++; $display("[TB] FAIL guard_rptr: got rd_addr=%0d count=%0d, expected 0 2", rd_addr, count_out); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd0) begin miscompares++; $display("[TB] FAIL restart_addr: got en=%0b addr=%0d, expected en=1 addr=0", wr_en, wr_addr); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (wr_addr !== 4'd1 || count_out !== 5'd1) begin miscompares++; $display("[TB] FAIL restart_next: got addr=%0d count=%0d, expected 1 1", wr_addr, count_out); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count_out !== 5'd2 || rd_avail !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_commit: got count=%0d avail=%0b, expected 2 1", count_out, rd_avail); end
    // reset mid-packet loses everything immediately
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b0;
    #1;
    vectors++;
    if (count_out !== 5'd0 || rd_avail !== 1'b0 || fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset: got count=%0d avail=%0b empty=%0b, expected 0 0 1", count_out, rd_avail, fifo_empty); end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    int writes;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i == 0, i == 9, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count_out !== 5'd10 || rd_avail !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_first: got count=%0d avail=%0b, expected 10 1", count_out, rd_avail); end
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i == 0, 1'b0, 1'b0, 1'b0);
      if (wr_en === 1'b1 && wr_addr === 4'(10 + i)) writes++;
      tick();
    end
    vectors++;
    if (writes != 6) begin miscompares++; $display("[TB] FAIL ovf_writes: got %0d, expected 6", writes); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (fifo_full !== 1'b1 || wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_byte7: got full=%0b en=%0b, expected 1 0", fifo_full, wr_en); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || count_out !== 5'd10) begin miscompares++; $display("[TB] FAIL ovf_pulse: got ovf=%0b count=%0d, expected 1 10", overflow, count_out); end
    vectors++;
    if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_drop_discard: got %0b, expected 0", wr_en); end
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_once: got %0b, expected 0", overflow); end
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd10) begin miscompares++; $display("[TB] FAIL ovf_resume: got en=%0b addr=%0d, expected 1 10", wr_en, wr_addr); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count_out !== 5'd11 || pkt_count !== exp_pkt(2)) begin miscompares++; $display("[TB] FAIL ovf_after: got count=%0d pkts=%0d, expected 11 %0d", count_out, pkt_count, exp_pkt(2)); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0, i == 15, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (fifo_full !== 1'b1 || wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL full_rw_discard: got full=%0b en=%0b, expected 1 0", fifo_full, wr_en); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || count_out !== 5'd15 || rd_addr !== 4'd1) begin miscompares++; $display("[TB] FAIL full_rw_after: got ovf=%0b count=%0d rd_addr=%0d, expected 1 15 1", overflow, count_out, rd_addr); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    int bad_addr;
    int bad_count;
    do_reset();
    bad_addr  = 0;
    bad_count = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      if (wr_en !== 1'b1 || wr_addr !== 4'(i % 16)) bad_addr++;
      tick();
      if (count_out !== 5'd1) bad_count++;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      if (count_out !== 5'd0) bad_count++;
    end
    vectors++;
    if (bad_addr != 0) begin miscompares++; $display("[TB] FAIL wrap_addr: got %0d wrong addresses, expected 0", bad_addr); end
    vectors++;
    if (bad_count != 0) begin miscompares++; $display("[TB] FAIL wrap_count: got %0d wrong counts, expected 0", bad_count); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rd_addr !== 4'd4 || fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_rd_addr: got %0d empty=%0b, expected 4 1", rd_addr, fifo_empty); end
  endtask

  task automatic test_pkt_count();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (pkt_count !== exp_pkt(2)) begin miscompares++; $display("[TB] FAIL pkt_two: got %0d, expected %0d", pkt_count, exp_pkt(2)); end
    tick();
    vectors++;
    if (pkt_count !== exp_pkt(2)) begin miscompares++; $display("[TB] FAIL pkt_mid: got %0d, expected %0d", pkt_count, exp_pkt(2)); end
    tick();
    vectors++;
    if (pkt_count !== exp_pkt(1)) begin miscompares++; $display("[TB] FAIL pkt_one: got %0d, expected %0d", pkt_count, exp_pkt(1)); end
    tick();
    tick();
    // pop the last byte of packet two while committing a one-byte packet
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (pkt_count !== exp_pkt(1) || count_out !== 5'd1) begin miscompares++; $display("[TB] FAIL pkt_inc_dec: got pkts=%0d count=%0d, expected %0d 1", pkt_count, count_out, exp_pkt(1)); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_rst       = 1'b0;
    wr_valid    = 1'b0;
    wr_sop      = 1'b0;
    wr_eop      = 1'b0;
    wr_err      = 1'b0;
    rd_en       = 1'b0;
    test_reset();
    test_three_byte();
    test_abort();
    test_restart_and_guard();
    test_overflow();
    test_full_rw();
    test_wrap();
    test_pkt_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_ctrl.md
FIFO_PKT_CTRL -- requirements
Module: fifo_pkt_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BITS, default 4, giving FIFO depth 2^DEPTH_BITS bytes; the RAM is external.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port wr_valid, input, 1, a byte is offered by the receiver this cycle.
REQ-005 SHALL have port wr_sop, input, 1, qualified by wr_valid; the byte is the first of a packet.
REQ-006 SHALL have port wr_eop, input, 1, qualified by wr_valid; the byte is the last of a packet.
REQ-007 SHALL have port wr_err, input, 1, abort strobe; it needs no wr_valid.
REQ-008 SHALL have port rd_en, input, 1, the consumer pops one committed byte.
REQ-009 SHALL have port wr_en, output, 1, the RAM write strobe.
REQ-010 SHALL have port wr_addr, output, DEPTH_BITS, the RAM write address.
REQ-011 SHALL have port rd_addr, output, DEPTH_BITS, the RAM read address (rptr[DEPTH_BITS-1:0]).
REQ-012 SHALL have port rd_avail, output, 1, at least one committed byte is readable.
REQ-013 SHALL have port count_out, output, DEPTH_BITS+1, the speculative occupancy (wptr-rptr).
REQ-014 SHALL have port fifo_full, output, 1, count_out == 2^DEPTH_BITS.
REQ-015 SHALL have port fifo_empty, output, 1, count_out == 0.
REQ-016 SHALL have port overflow, output, 1, a one-cycle pulse when a packet is dropped for lack of space.
REQ-017 SHALL have port pkt_count, output, DEPTH_BITS+1, the number of committed unread packets (see Configuration).

Function
REQ-018 SHALL keep the DEPTH_BITS+1-bit registered pointers wptr (speculative write), cptr (committed write) and rptr (read), all wrapping modulo 2^(DEPTH_BITS+1).
REQ-019 SHALL derive all outputs except wr_en/wr_addr from registered state only; rd_avail = (cptr != rptr).
REQ-020 SHALL implement the FSM states IDLE, RECV and DROP.
REQ-021 SHALL treat the input stream as non-stallable; there is no wr_ready, and every wr_valid byte is either written or discarded.
REQ-022 IDLE: wr_valid&wr_sop with space available SHALL write at wptr, increment wptr and go to RECV; if wr_eop is also set, it SHALL commit immediately (cptr<=wptr+1) and stay in IDLE.
REQ-023 IDLE: wr_valid without wr_sop SHALL be discarded with no write.
REQ-024 RECV: wr_valid with space available SHALL write and increment wptr; with wr_eop it SHALL set cptr<=wptr+1 and go to IDLE.
REQ-025 RECV: wr_valid&wr_sop SHALL discard the partial packet, write the byte at cptr, set wptr<=cptr+1 and stay in RECV.
REQ-026 RECV: wr_err SHALL set wptr<=cptr, suppress wr_en and go to IDLE; wr_err overrides wr_valid, wr_sop and wr_eop in the same cycle.
REQ-027 A byte arriving in IDLE/RECV while fifo_full SHALL be discarded, set wptr<=cptr and pulse overflow; the FSM SHALL go to DROP, or to IDLE if that byte carried wr_eop.
REQ-028 DROP: bytes SHALL be discarded; wr_eop or wr_err SHALL return to IDLE; wr_sop with space available SHALL start a new packet as in REQ-022.
REQ-029 wr_en SHALL be combinational, equal to wr_valid & accepted-write, with wr_addr = write index[DEPTH_BITS-1:0].
REQ-030 rd_en with rd_avail SHALL increment rptr; rd_en without rd_avail SHALL be ignored.
REQ-031 A read and a write in the same cycle SHALL both take effect; space for a write is computed from the pre-edge count_out.
REQ-032 A read SHALL never pass cptr; uncommitted bytes are never readable.

Reset
REQ-033 n_rst low SHALL immediately force wptr=cptr=rptr=0, state IDLE, pkt_count=0, overflow=0, fifo_empty=1, fifo_full=0 and rd_avail=0.
REQ-034 Reset mid-packet SHALL lose all data; no commit is performed.

Configuration
REQ-035 Macro FIFO_PKT_CNT_EN defined: pkt_count SHALL increment on each commit and decrement when a popped byte is the last of a packet, with an internal EOP-marker bitmap of 2^DEPTH_BITS bits; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-036 Macro FIFO_PKT_CNT_EN undefined: pkt_count SHALL be tied to 0, the bitmap SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (DEPTH_BITS=4)
REQ-037 3-byte packet (sop, -, eop) -> wr_addr 0,1,2; cptr=3 one cycle after eop; rd_avail=1; count_out=3.
REQ-038 sop + 2 bytes then wr_err -> wptr back to 0; count_out=0; rd_avail stays 0; no wr_en in the err cycle.
REQ-039 Committed 10-byte packet, then 8-byte packet -> 6 bytes written, byte 7 discarded, overflow pulses once, count_out=10, DROP until eop, then IDLE.
REQ-040 Full FIFO, rd_en and wr_valid&wr_sop in the same cycle -> the new byte is discarded as overflow and rptr increments.
REQ-041 Pointer wrap: 20 single-byte packets, each read immediately -> wr_addr wraps 15->0; count_out never exceeds 1.
REQ-042 FIFO_PKT_CNT_EN: two committed packets -> pkt_count=2; reading through the first packet's last byte -> pkt_count=1.
